// File: rtl/sha256_round_ctrl.sv
// SHA-256 per-block round controller: sequences IV load, working-variable init,
// ROUNDS compression rounds, hash update and a done pulse. Optional stall: SHA256_ROUND_CTRL_STALL_EN.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       first_blk,
`ifdef SHA256_ROUND_CTRL_STALL_EN
  input  logic       w_valid,
`endif
  output logic       ready,
  output logic [5:0] w_cnt,
  output logic       load_iv,
  output logic       init_wv,
  output logic       round_en,
  output logic       msg_sel,
  output logic       update_hv,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_e;

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [5:0] w_cnt_q, w_cnt_d;
  logic       first_q, first_d;
  logic       w_ok;

`ifdef SHA256_ROUND_CTRL_STALL_EN
  assign w_ok = w_valid;
`else
  assign w_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_cnt_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_cnt_q <= w_cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_cnt_d   = w_cnt_q;
    first_d   = first_q;
    ready     = 1'b0;
    load_iv   = 1'b0;
    init_wv   = 1'b0;
    round_en  = 1'b0;
    update_hv = 1'b0;
    done      = 1'b0;
    msg_sel   = (state_q == S_ROUND) && (w_cnt_q < 6'd16);
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = S_INIT;
          first_d = first_blk;
          w_cnt_d = '0;
        end
      end
      S_INIT: begin
        init_wv = 1'b1;
        load_iv = first_q;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        // Only message-word rounds can stall; w_cnt saturates at the last round.
        if (!msg_sel || w_ok) begin
          round_en = 1'b1;
          if (w_cnt_q == LAST_RND) state_d = S_UPDATE;
          else                     w_cnt_d = w_cnt_q + 6'd1;
        end
      end
      S_UPDATE: begin
        update_hv = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_cnt = w_cnt_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Randomized bench for sha256_round_ctrl: a ROUNDS=64 and a ROUNDS=4 instance
// are compared every cycle against a phase-counter reference model.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic first_blk = 1'b0;
  logic w_valid = 1'b1;

`ifdef SHA256_ROUND_CTRL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic       ready_o[2];
  logic [5:0] wcnt_o[2];
  logic       load_iv_o[2];
  logic       init_wv_o[2];
  logic       round_en_o[2];
  logic       msg_sel_o[2];
  logic       update_hv_o[2];
  logic       done_o[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_round_ctrl #(.ROUNDS(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start), .first_blk(first_blk),
`ifdef SHA256_ROUND_CTRL_STALL_EN
    .w_valid(w_valid),
`endif
    .ready(ready_o[0]), .w_cnt(wcnt_o[0]), .load_iv(load_iv_o[0]),
    .init_wv(init_wv_o[0]), .round_en(round_en_o[0]), .msg_sel(msg_sel_o[0]),
    .update_hv(update_hv_o[0]), .done(done_o[0])
  );

  sha256_round_ctrl #(.ROUNDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .first_blk(first_blk),
`ifdef SHA256_ROUND_CTRL_STALL_EN
    .w_valid(w_valid),
`endif
    .ready(ready_o[1]), .w_cnt(wcnt_o[1]), .load_iv(load_iv_o[1]),
    .init_wv(init_wv_o[1]), .round_en(round_en_o[1]), .msg_sel(msg_sel_o[1]),
    .update_hv(update_hv_o[1]), .done(done_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rounds_of(input int i);
    return (i == 0) ? 64 : 4;
  endfunction

  // Model: phase p = cycles since start was accepted (0 = idle), 1 = init,
  // 2..R+1 = round p-2, R+2 = update, R+3 = done. Stalls freeze p.
  int p[2];
  bit mfirst[2];
  int mwcnt[2];
  int accept_cyc[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      p[i] = 0; mfirst[i] = 1'b0; mwcnt[i] = 0; accept_cyc[i] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst       = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if (cyc == 2)                    start = 1'b1;
      else if (((cyc / 500) % 2) == 1) start = 1'b1;
      else                             start = ($urandom_range(0, 3) == 0);
      first_blk = (cyc == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      w_valid   = STALL ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
        int  r;
        bit  in_rnd;
        bit  msg;
        bit  stall;
        string sfx;
        r      = rounds_of(i);
        sfx    = $sformatf("[R=%0d]", r);
        in_rnd = (p[i] >= 2) && (p[i] <= r + 1);
        msg    = in_rnd && ((p[i] - 2) < 16);
        stall  = STALL && msg && !w_valid;
        chk({"ready", sfx},     32'(ready_o[i]),     32'(p[i] == 0));
        chk({"w_cnt", sfx},     32'(wcnt_o[i]),      32'(mwcnt[i]));
        chk({"init_wv", sfx},   32'(init_wv_o[i]),   32'(p[i] == 1));
        chk({"load_iv", sfx},   32'(load_iv_o[i]),   32'((p[i] == 1) && mfirst[i]));
        chk({"round_en", sfx},  32'(round_en_o[i]),  32'(in_rnd && !stall));
        chk({"msg_sel", sfx},   32'(msg_sel_o[i]),   32'(msg));
        chk({"update_hv", sfx}, 32'(update_hv_o[i]), 32'(p[i] == r + 2));
        chk({"done", sfx},      32'(done_o[i]),      32'(p[i] == r + 3));
        chk({"excl", sfx},
            32'($countones({init_wv_o[i], load_iv_o[i] & ~init_wv_o[i], round_en_o[i],
                            update_hv_o[i], done_o[i]}) <= 1), 32'd1);
        if (done_o[i] === 1'b1 && !STALL)
          chk({"latency", sfx}, 32'(cyc - accept_cyc[i]), 32'(r + 3));
        if (rst) begin
          p[i] = 0; mfirst[i] = 1'b0; mwcnt[i] = 0;
        end else if (p[i] == 0) begin
          if (start) begin
            p[i] = 1; mfirst[i] = first_blk; mwcnt[i] = 0; accept_cyc[i] = cyc;
          end
        end else if (p[i] == r + 3) begin
          p[i] = 0;
        end else if (!stall) begin
          if (p[i] >= 2 && p[i] < r + 1) mwcnt[i] = p[i] - 1;
          p[i] = p[i] + 1;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
